// File: rtl/uart_rx_io_pkg.sv
// Shared constants for the UART receive IO block: IO port numbers, status bit
// positions, receiver state encoding and buffer depth.
// Build option UART_RX_FIFO_EN: 4-entry receive FIFO instead of one holding register.
package uart_rx_io_pkg;

  localparam logic [7:0] PORT_DATA   = 8'h01;
  localparam logic [7:0] PORT_STATUS = 8'h03;

  localparam int ST_AVAIL   = 0;
  localparam int ST_OVERRUN = 1;
  localparam int ST_FRAMING = 2;
  localparam int ST_FULL    = 3;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rxState_t;

`ifdef UART_RX_FIFO_EN
  localparam int FIFO_DEPTH = 4;
`else
  localparam int FIFO_DEPTH = 1;
`endif

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer for uart_rx_io. A pop is applied before a push in the same
// cycle, so a full buffer still accepts a byte when it is read at that moment.
// Build option UART_RX_FIFO_EN: 4-entry FIFO; otherwise a single holding register.
module uart_rx_fifo
  import uart_rx_io_pkg::*;
(
  input  logic       clk,
  input  logic       nRESET,
  input  logic       push,
  input  logic [7:0] pushData,
  input  logic       pop,
  output logic [7:0] headData,
  output logic       full,
  output logic [2:0] count,
  output logic       overrunSet
);

`ifdef UART_RX_FIFO_EN
  logic [7:0] mem [FIFO_DEPTH];
  logic [1:0] rdPtr;
  logic [1:0] wrPtr;
  logic [2:0] cnt;
  logic [2:0] cntAfterPop;
  logic       doPop;
  logic       doPush;

  // pop first, then decide whether the push fits
  always_comb begin
    doPop       = pop && (cnt != 3'd0);
    cntAfterPop = cnt - {2'b00, doPop};
    doPush      = push && (cntAfterPop != 3'(FIFO_DEPTH));
    overrunSet  = push && !doPush;
  end

  // pointers wrap 3 -> 0; occupancy 0..4
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      rdPtr <= 2'd0;
      wrPtr <= 2'd0;
      cnt   <= 3'd0;
    end else begin
      if (doPop)  rdPtr <= rdPtr + 2'd1;
      if (doPush) wrPtr <= wrPtr + 2'd1;
      cnt <= cntAfterPop + {2'b00, doPush};
    end
  end

  // storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  assign headData = mem[rdPtr];
  assign full     = (cnt == 3'(FIFO_DEPTH));
  assign count    = cnt;
`else
  logic [7:0] holdReg;
  logic       valid;
  logic       doPop;
  logic       doPush;

  // a pop frees the register for a push in the same cycle
  always_comb begin
    doPop      = pop && valid;
    doPush     = push && (!valid || doPop);
    overrunSet = push && !doPush;
  end

  // holding register with its valid bit
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      holdReg <= 8'h00;
      valid   <= 1'b0;
    end else begin
      valid <= doPush || (valid && !doPop);
      if (doPush) holdReg <= pushData;
    end
  end

  assign headData = holdReg;
  assign full     = valid;
  assign count    = {2'b00, valid};
`endif

endmodule

// File: rtl/uart_rx_io.sv
// 8N1 UART receiver with a CPU IO-port interface (data port 0x01, status 0x03).
// Build option UART_RX_FIFO_EN: 4-entry receive FIFO instead of one holding register.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | counting to mid start bit, rejecting glitches
// DATA  | sampling 8 data bits, LSB first
// STOP  | sampling the stop bit
// BREAK | framing error seen, waiting for the line to return high
module uart_rx_io
  import uart_rx_io_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int OVS    = 16
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       uart_rx,
  input  logic [7:0] Address,
  input  logic       IORQ,
  input  logic       RD,
  output logic [7:0] DataOut,
  output logic       data_oe,
  output logic       nINT_RX
);

  localparam int DIV  = CLK_HZ / (BAUD * OVS);
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNTW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [CNTW-1:0] HALF_LAST = CNTW'(OVS / 2 - 1);
  localparam logic [CNTW-1:0] FULL_LAST = CNTW'(OVS - 1);

  logic [1:0]      rxSync;
  logic [1:0]      iorqSync;
  logic [1:0]      rdSync;
  logic            rxPrev;
  logic            rxS;
  logic            rxFall;
  logic [DIVW-1:0] divCnt;
  logic            tick;

  rxState_t        state, stateNext;
  logic [CNTW-1:0] sampleCnt, cntNext;
  logic [2:0]      bitIdx, bitNext;
  logic [7:0]      shiftReg, shiftNext;
  logic            breakHigh, breakHighNext;
  logic            pushEn;
  logic            frameErr;

  logic [7:0]      headData;
  logic            fifoFull;
  logic [2:0]      fifoCount;
  logic            overrunSet;
  logic            avail;
  logic            overrunFlag;
  logic            framingFlag;
  logic            selData;
  logic            selStat;
  logic            oeNext;
  logic            oePrev;
  logic            readWasData;
  logic            popReq;
  logic            clrReq;
  logic [7:0]      statusByte;

  // synchronizers for the line and the CPU strobes; rxPrev feeds edge detection
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      rxSync   <= 2'b11;
      iorqSync <= 2'b00;
      rdSync   <= 2'b00;
      rxPrev   <= 1'b1;
    end else begin
      rxSync   <= {rxSync[0], uart_rx};
      iorqSync <= {iorqSync[0], IORQ};
      rdSync   <= {rdSync[0], RD};
      rxPrev   <= rxSync[1];
    end
  end

  assign rxS    = rxSync[1];
  assign rxFall = rxPrev && !rxS;
  assign tick   = (divCnt == DIVW'(DIV - 1));

  // free-running oversample tick divider
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) divCnt <= '0;
    else         divCnt <= tick ? '0 : divCnt + DIVW'(1);
  end

  // receiver state and datapath registers
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state     <= IDLE;
      sampleCnt <= '0;
      bitIdx    <= 3'd0;
      shiftReg  <= 8'h00;
      breakHigh <= 1'b0;
    end else begin
      state     <= stateNext;
      sampleCnt <= cntNext;
      bitIdx    <= bitNext;
      shiftReg  <= shiftNext;
      breakHigh <= breakHighNext;
    end
  end

  // receiver next-state, sampling and push/error strobes
  always_comb begin
    stateNext     = state;
    cntNext       = sampleCnt;
    bitNext       = bitIdx;
    shiftNext     = shiftReg;
    breakHighNext = breakHigh;
    pushEn        = 1'b0;
    frameErr      = 1'b0;
    case (state)
      IDLE: begin
        if (rxFall) begin
          stateNext = START;
          cntNext   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (sampleCnt == HALF_LAST) begin
            cntNext   = '0;
            bitNext   = 3'd0;
            stateNext = rxS ? IDLE : DATA;
          end else begin
            cntNext = sampleCnt + CNTW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (sampleCnt == FULL_LAST) begin
            cntNext   = '0;
            shiftNext = {rxS, shiftReg[7:1]};
            if (bitIdx == 3'd7) stateNext = STOP;
            else                bitNext   = bitIdx + 3'd1;
          end else begin
            cntNext = sampleCnt + CNTW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (sampleCnt == FULL_LAST) begin
            cntNext = '0;
            if (rxS) begin
              pushEn    = 1'b1;
              stateNext = IDLE;
            end else begin
              frameErr      = 1'b1;
              breakHighNext = 1'b0;
              stateNext     = BREAK;
            end
          end else begin
            cntNext = sampleCnt + CNTW'(1);
          end
        end
      end
      BREAK: begin
        // leave only after the line has stayed high across a whole tick period
        if (!rxS) begin
          breakHighNext = 1'b0;
        end else if (tick) begin
          if (breakHigh) stateNext = IDLE;
          else           breakHighNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  uart_rx_fifo u_fifo (
    .clk        (clk),
    .nRESET     (nRESET),
    .push       (pushEn),
    .pushData   (shiftReg),
    .pop        (popReq),
    .headData   (headData),
    .full       (fifoFull),
    .count      (fifoCount),
    .overrunSet (overrunSet)
  );

  // port decode, status assembly and end-of-read side effects
  always_comb begin
    avail      = (fifoCount != 3'd0);
    selData    = (Address == PORT_DATA);
    selStat    = (Address == PORT_STATUS);
    oeNext     = iorqSync[1] && rdSync[1] && (selData || selStat);
    popReq     = oePrev && !data_oe && readWasData;
    clrReq     = oePrev && !data_oe && !readWasData;
    statusByte = 8'h00;
    statusByte[ST_AVAIL]   = avail;
    statusByte[ST_OVERRUN] = overrunFlag;
    statusByte[ST_FRAMING] = framingFlag;
    statusByte[ST_FULL]    = fifoFull;
  end

  // registered bus outputs, flags (set beats clear) and interrupt
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      data_oe     <= 1'b0;
      DataOut     <= 8'h00;
      oePrev      <= 1'b0;
      readWasData <= 1'b0;
      overrunFlag <= 1'b0;
      framingFlag <= 1'b0;
      nINT_RX     <= 1'b1;
    end else begin
      data_oe <= oeNext;
      oePrev  <= data_oe;
      if (oeNext) begin
        readWasData <= selData;
        DataOut     <= selData ? (avail ? headData : 8'h00) : statusByte;
      end else begin
        DataOut     <= 8'h00;
      end
      if (overrunSet)  overrunFlag <= 1'b1;
      else if (clrReq) overrunFlag <= 1'b0;
      if (frameErr)    framingFlag <= 1'b1;
      else if (clrReq) framingFlag <= 1'b0;
      nINT_RX <= !avail;
    end
  end

endmodule

// File: doc/uart_rx_io.md
UART_RX_IO -- requirements
Module: uart_rx_io

Interface
REQ-001 Parameter CLK_HZ, default 50000000, frequency of clk in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter OVS, default 16, oversampling factor, power of two.
REQ-004 clk  input  1  receiver clock (50 MHz UART clock); the only clock.
REQ-005 nRESET  input  1  asynchronous, active-low reset.
REQ-006 uart_rx  input  1  serial line, idle high, 8N1, asynchronous to clk.
REQ-007 Address  input  8  CPU address bits A[15:8] during an IO cycle.
REQ-008 IORQ  input  1  active-high IO request, already inverted from nIORQ.
REQ-009 RD  input  1  active-high read strobe, already inverted from nRD.
REQ-010 DataOut  output  8  read data toward the CPU data bus.
REQ-011 data_oe  output  1  high while this block is driving DataOut for a selected read.
REQ-012 nINT_RX  output  1  active-low level request, low while receive data is available.

Function
REQ-013 uart_rx, IORQ and RD SHALL each pass through a 2-flop synchronizer before use; uart_rx's synchronizer resets to 1.
REQ-014 Tick divider SHALL pulse once every DIV = CLK_HZ/(BAUD*OVS) clk cycles, integer-truncated (27 at defaults); the divider wraps from DIV-1 to 0.
REQ-015 RX FSM states: IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE -> START on a synchronized falling edge of uart_rx; the sample counter clears.
REQ-017 START: at tick OVS/2 the line is sampled; low -> DATA; high -> IDLE (glitch rejection, no flags change).
REQ-018 DATA: 8 bits, LSB first, each sampled at tick OVS after the previous sample point; after bit 7 -> STOP.
REQ-019 STOP: sampled at tick OVS; high -> byte pushed, -> IDLE; low -> framing-error flag set, byte discarded, -> BREAK.
REQ-020 BREAK: stay until the synchronized line reads high for one full tick, then -> IDLE.
REQ-021 Port select: port 0x01 = data, port 0x03 = status; any other Address is ignored.
REQ-022 data_oe = IORQ & RD & (port 0x01 or 0x03), from synchronized strobes; DataOut SHALL be 0 whenever data_oe is 0.
REQ-023 Data read: DataOut = FIFO head; 0x00 if empty.
REQ-024 Status read: bit0 data available, bit1 overrun, bit2 framing error, bit3 FIFO full, bits7:4 = 0.
REQ-025 Pop SHALL occur exactly once, on the clk after data_oe falls following a port 0x01 read; a pop on empty is a no-op.
REQ-026 Clearing of overrun and framing-error flags SHALL occur on the clk after data_oe falls following a port 0x03 read.
REQ-027 Push to a full FIFO SHALL drop the new byte and set overrun; stored bytes are unchanged.
REQ-028 Simultaneous push and pop: pop applies first, then push; a full FIFO therefore accepts the byte and no overrun is raised.
REQ-029 Flag set and clear in the same cycle: set wins.
REQ-030 nINT_RX = ~(data available), registered.

Reset
REQ-031 On nRESET low: FSM = IDLE, divider and counters = 0, FIFO empty, flags = 0, synchronizers = idle (uart_rx 1, strobes 0), DataOut = 0, data_oe = 0, nINT_RX = 1.
REQ-032 Reset mid-frame SHALL abandon the frame; the first edge after release starts a fresh frame.

Configuration
REQ-033 With UART_RX_FIFO_EN defined: 4-entry FIFO, 2-bit pointers wrapping 3 -> 0, plus a count of 0..4.
REQ-034 Without UART_RX_FIFO_EN: single holding register with a valid bit; full = valid; all overrun and pop rules apply unchanged.

Structure
REQ-035 Shared package holds: port numbers 0x01/0x03, status bit positions, the FSM state enum, and the FIFO depth constant.
REQ-036 One sub-module, uart_rx_fifo, contains the FIFO (or the holding register) and the push/pop ordering.

Verification
REQ-037 Line sends 0xA5 at 115200 baud -> status reads 0x01; data read returns 0xA5; status then reads 0x00; nINT_RX 0 then 1.
REQ-038 50-cycle low glitch on idle line -> no byte, status 0x00, FSM back in IDLE.
REQ-039 With FIFO: send 0x11, 0x22, 0x33, 0x44, 0x55 with no reads -> status 0x0B; reads return 0x11..0x44; the next status read returns 0x00, and the read after it returns 0x00.
REQ-040 Frame 0x3C with stop bit low, then line held low for 2 ms, then 0x5A -> status 0x05, data 0x5A; a second status read returns 0x00.
REQ-041 Push and pop in the same clk with the FIFO full -> no overrun, count unchanged, order preserved.
REQ-042 nRESET pulsed low at data bit 4 of a frame, then 0x81 sent -> only 0x81 is received, with no framing error.
